// File: rtl/bram_read_arbiter_if.sv
// Handshake bundle between the strip drivers, the read arbiter and the frame BRAM.
// The slave modport is the arbiter's view; master is the requester/BRAM side.
interface bram_read_arbiter_if #(
    parameter int NUM_CHANNELS  = 8,
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 8
);
    logic [NUM_CHANNELS-1:0]               data_req;
    logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] data_addr;
    logic [NUM_CHANNELS-1:0]               data_rdy;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data;
    logic                                  mem_ren;
    logic [ADDRESS_WIDTH-1:0]              mem_raddr;
    logic [DATA_WIDTH-1:0]                 mem_rdata;

    modport slave (
        input  data_req,
        input  data_addr,
        input  mem_rdata,
        output data_rdy,
        output data,
        output mem_ren,
        output mem_raddr
    );

    modport master (
        output data_req,
        output data_addr,
        output mem_rdata,
        input  data_rdy,
        input  data,
        input  mem_ren,
        input  mem_raddr
    );
endinterface

// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port among NUM_CHANNELS requesters (round-robin or fixed
// priority), one issue per clock, with a tag pipeline steering data back per channel.
module bram_read_arbiter #(
    parameter int NUM_CHANNELS  = 8,
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_LATENCY   = 1,
    parameter int PRIORITY_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    bram_read_arbiter_if.slave io_bus
);
    localparam int            IW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IW-1:0] LAST_CH = IW'(NUM_CHANNELS - 1);

    logic [NUM_CHANNELS-1:0]                 r_pending;
    logic [NUM_CHANNELS-1:0]                 r_data_rdy;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_data;
    logic                                    r_mem_ren;
    logic [ADDRESS_WIDTH-1:0]                r_mem_raddr;
    logic [IW-1:0]                           r_issue_ch;
    logic [IW-1:0]                           r_last_grant;
    logic [MEM_LATENCY-1:0]                  r_tag_valid;
    logic [IW-1:0]                           r_tag_ch [MEM_LATENCY];

    logic [NUM_CHANNELS-1:0]  w_eligible;
    logic [NUM_CHANNELS-1:0]  w_grant_onehot;
    logic [NUM_CHANNELS-1:0]  w_done;
    logic [IW-1:0]            w_search_start;
    logic                     w_grant_valid;
    logic [IW-1:0]            w_grant_ch;
    logic [ADDRESS_WIDTH-1:0] w_grant_addr;
    logic                     w_tag_out_valid;
    logic [IW-1:0]            w_tag_out_ch;
    int                       w_idx;
    logic [IW-1:0]            w_cand;

    // Wrap is explicit so non-power-of-two channel counts rotate correctly.
    always_comb begin
        w_search_start = '0;
        if (PRIORITY_MODE == 0 && r_last_grant != LAST_CH) begin
            w_search_start = r_last_grant + IW'(1);
        end
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_ch    = '0;
        w_idx         = 0;
        w_cand        = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_idx = int'(w_search_start) + i;
            if (w_idx >= NUM_CHANNELS) begin
                w_idx = w_idx - NUM_CHANNELS;
            end
            w_cand = IW'(w_idx);
            if (!w_grant_valid && w_eligible[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_ch    = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_addr = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_grant_onehot[k]) begin
                w_grant_addr = w_grant_addr | io_bus.data_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    assign w_tag_out_valid = r_tag_valid[MEM_LATENCY-1];
    assign w_tag_out_ch    = r_tag_ch[MEM_LATENCY-1];

    // Stage 0 of the tag travels with mem_ren; the last stage lines up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_ren    <= 1'b0;
            r_mem_raddr  <= '0;
            r_issue_ch   <= '0;
            r_last_grant <= LAST_CH;
            r_tag_valid  <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                r_tag_ch[k] <= '0;
            end
        end else begin
            r_mem_ren      <= w_grant_valid;
            r_issue_ch     <= w_grant_ch;
            if (w_grant_valid) begin
                r_mem_raddr  <= w_grant_addr;
                r_last_grant <= w_grant_ch;
            end
            r_tag_valid[0] <= r_mem_ren;
            r_tag_ch[0]    <= r_issue_ch;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                r_tag_valid[k] <= r_tag_valid[k-1];
                r_tag_ch[k]    <= r_tag_ch[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        // Masking with data_rdy absorbs a registered requester's late deassertion.
        assign w_eligible[gi]     = io_bus.data_req[gi] & ~r_pending[gi] & ~r_data_rdy[gi];
        assign w_grant_onehot[gi] = w_grant_valid && (w_grant_ch == IW'(gi));
        assign w_done[gi]         = w_tag_out_valid && (w_tag_out_ch == IW'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pending[gi]  <= 1'b0;
                r_data_rdy[gi] <= 1'b0;
                r_data[gi]     <= '0;
            end else begin
                r_data_rdy[gi] <= w_done[gi];
                if (w_done[gi]) begin
                    r_data[gi]    <= io_bus.mem_rdata;
                    r_pending[gi] <= 1'b0;
                end else if (w_grant_onehot[gi]) begin
                    r_pending[gi] <= 1'b1;
                end
            end
        end
    end

    assign io_bus.data_rdy  = r_data_rdy;
    assign io_bus.data      = r_data;
    assign io_bus.mem_ren   = r_mem_ren;
    assign io_bus.mem_raddr = r_mem_raddr;
endmodule
